add_roundkey_stream: RTL

Parametrised, streaming successor to the combinational AddRoundKey stage. It accepts the 128-bit AES state as a sequence of DATA_W-bit beats over a valid/ready handshake. Each beat is XORed with the matching slice of the 128-bit round key, and the result is returned through a registered output stage. It sits between narrow-datapath AES stages (SubBytes/ShiftRows/MixColumns) and the key schedule, where a full 128-bit bus is too costly.

---
 rtl/add_roundkey_stream.sv | 78 +++++++
 1 files changed

// File: rtl/add_roundkey_stream.sv
// Streaming AddRoundKey: XORs DATA_W-bit beats of the AES state with the matching
// slice of a round key that is captured on the first beat of every block.
module add_roundkey_stream #(
  parameter int DATA_W = 32,
  parameter int BEATS  = 128 / DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [127:0]      round_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              frame_err
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SLOTS = 1 << CNT_W;

  if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32 || DATA_W == 64 || DATA_W == 128)
      || BEATS != 128 / DATA_W) begin : g_bad_width
    $error("add_roundkey_stream: DATA_W must be 8/16/32/64/128 and BEATS must stay 128/DATA_W");
  end

  logic [CNT_W-1:0]  beat_cnt_r;
  logic [127:0]      key_q_r;
  logic              accept_s;
  logic              last_idx_s;
  logic [DATA_W-1:0] key_slice_s;
  logic [DATA_W-1:0] key_words_s [SLOTS];

  // Padding slots exist only so the beat counter can index the table at full width.
  for (genvar k = 0; k < SLOTS; k++) begin : g_slot
    if (k < BEATS) begin : g_real
      assign key_words_s[k] = key_q_r[127 - k*DATA_W -: DATA_W];
    end else begin : g_pad
      assign key_words_s[k] = {DATA_W{1'b0}};
    end
  end

  assign in_ready    = !out_valid || out_ready;
  assign accept_s    = in_valid && in_ready;
  assign last_idx_s  = (beat_cnt_r == CNT_W'(BEATS - 1));
  // Beat 0 must use the live key because key_q_r is only being loaded on that edge.
  assign key_slice_s = (beat_cnt_r == CNT_W'(0)) ? round_key[127 -: DATA_W]
                                                 : key_words_s[beat_cnt_r];

  // Output register, key capture, beat counter and framing pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= {DATA_W{1'b0}};
      out_last   <= 1'b0;
      frame_err  <= 1'b0;
      beat_cnt_r <= {CNT_W{1'b0}};
      key_q_r    <= 128'd0;
    end else begin
      frame_err <= accept_s && (in_last != last_idx_s);
      if (accept_s) begin
        out_valid <= 1'b1;
        out_data  <= in_data ^ key_slice_s;
        out_last  <= in_last;
        if (beat_cnt_r == CNT_W'(0)) begin
          key_q_r <= round_key;
        end
        // A framing error still resyncs: short blocks end at in_last, long ones wrap.
        beat_cnt_r <= (in_last || last_idx_s) ? {CNT_W{1'b0}} : beat_cnt_r + CNT_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
